// File: rtl/regfile_pkg.sv
// Shared widths, scan FSM state encoding and beat record for the register-file scanner.
package regfile_pkg;

    localparam int unsigned REGFILE_DATA_W   = 4;
    localparam int unsigned REGFILE_ADDR_W   = 3;
    localparam int unsigned REGFILE_NUM_REGS = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        HOLD,
        DONE
    } scan_state_t;

    typedef struct packed {
        logic [REGFILE_ADDR_W-1:0] addr;
        logic [REGFILE_DATA_W-1:0] data;
    } scan_beat_t;

endpackage

// File: rtl/regfile_scanner.sv
// Walks the register file read port and streams (addr, data) beats out on valid/ready.
// Define REGFILE_SCANNER_SKIP_ZERO_EN to suppress beats for registers that read as zero.
module regfile_scanner
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = REGFILE_DATA_W,
    parameter int unsigned ADDR_W   = REGFILE_ADDR_W,
    parameter int unsigned NUM_REGS = REGFILE_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skip_beat;

`ifdef REGFILE_SCANNER_SKIP_ZERO_EN
    assign skip_beat = (rf_read_data == '0);
`else
    assign skip_beat = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                if (skip_beat) begin
                    // Suppressed beat: advance exactly as a completed handshake would.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ISSUE;
                    end
                end else begin
                    out_data_d  = rf_read_data;
                    out_addr_d  = idx_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy         = (state_q == ISSUE) || (state_q == CAPTURE) || (state_q == HOLD);
    assign done         = (state_q == DONE);
    assign rf_read_addr = idx_q;
    assign out_valid    = out_valid_q;
    assign out_addr     = out_addr_q;
    assign out_data     = out_data_q;

endmodule

// File: tb/tb_regfile_scanner.sv
// Directed bench for regfile_scanner with a registered-read register file model and beat scoreboard.
module tb_regfile_scanner;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic       busy, done, out_valid;
    logic [2:0] rf_read_addr, out_addr;
    logic [3:0] rf_read_data, out_data;
    logic [3:0] mem [8];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cyc0 = 0;
    int beats = 0;
    int done_cnt = 0;
    int gaps = 0;
    int dc = 0;
    scan_beat_t exp_q[$];

    always #5 clk = ~clk;

    // Register file read port: one-cycle registered latency.
    always @(posedge clk) rf_read_data <= mem[rf_read_addr];

    regfile_scanner dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scores the beat (if any) that the coming rising edge will accept.
    task automatic monitor();
        scan_beat_t b;
        if (!reset && out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                b = exp_q.pop_front();
                chk("beat_addr", 32'(out_addr), 32'(b.addr));
                chk("beat_data", 32'(out_data), 32'(b.data));
            end
        end
        if (!reset && done) done_cnt++;
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        monitor();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc - cyc0 < n) tick();
    endtask

    task automatic load(input logic [31:0] vals);
        for (int i = 0; i < 8; i++) mem[i] = vals[4*i +: 4];
    endtask

    task automatic push_all();
        scan_beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.addr = 3'(i);
            b.data = mem[i];
`ifdef REGFILE_SCANNER_SKIP_ZERO_EN
            if (b.data != 4'h0) exp_q.push_back(b);
`else
            exp_q.push_back(b);
`endif
        end
    endtask

    // Leaves the bench at the falling edge of cycle 1 (first cycle after the start edge).
    task automatic start_scan(input bit hold_extra);
        start = 1'b1;
        tick();
        cyc0 = cyc - 1;
        if (hold_extra) tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = -1;
        gaps = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                c = cyc - cyc0;
                break;
            end
            if (!busy) gaps++;
            tick();
        end
        if (c < 0) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic finish_check(input string tag, input int exp_beats);
        tick();
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_beats"}, 32'(beats), 32'(exp_beats));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        load(32'h8765_4321);
        @(negedge clk);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rf_addr", 32'(rf_read_addr), 32'd0);
        reset = 1'b0;
        tick();

        // Full scan with ready held high.
        beats = 0; done_cnt = 0;
        push_all();
        start_scan(1'b0);
        chk("t1_busy_cycle1", 32'(busy), 32'd1);
        wait_done(dc);
        chk("t1_done_cycle", 32'(dc), 32'd25);
        chk("t1_busy_gaps", 32'(gaps), 32'd0);
        chk("t1_busy_in_done", 32'(busy), 32'd0);
        finish_check("t1", 8);

        // Backpressure on beat 3 for five cycles.
        beats = 0; done_cnt = 0;
        push_all();
        start_scan(1'b0);
        goto(11);
        out_ready = 1'b0;
        for (int k = 12; k <= 16; k++) begin
            goto(k);
            chk("t2_hold_valid", 32'(out_valid), 32'd1);
            chk("t2_hold_addr", 32'(out_addr), 32'd3);
            chk("t2_hold_data", 32'(out_data), 32'd4);
        end
        goto(17);
        out_ready = 1'b1;
        chk("t2_still_valid", 32'(out_valid), 32'd1);
        wait_done(dc);
        chk("t2_done_cycle", 32'(dc), 32'd30);
        finish_check("t2", 8);

        // Start re-asserted in cycle 1 and in the DONE cycle must be ignored.
        beats = 0; done_cnt = 0;
        push_all();
        start_scan(1'b1);
        wait_done(dc);
        chk("t3_done_cycle", 32'(dc), 32'd25);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("t3_idle_busy", 32'(busy), 32'd0);
        chk("t3_idle_valid", 32'(out_valid), 32'd0);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);
        chk("t3_beats", 32'(beats), 32'd8);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Register write during scan: r2 rewritten while beat 1 is held.
        beats = 0; done_cnt = 0;
        push_all();
        exp_q[2].data = 4'hA;
        start_scan(1'b0);
        goto(6);
        mem[2] = 4'hA;
        wait_done(dc);
        chk("t5_done_cycle", 32'(dc), 32'd25);
        finish_check("t5", 8);

        // Reset while holding beat 5: remaining beats dropped, no done.
        beats = 0; done_cnt = 0;
        load(32'h8765_4321);
        push_all();
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        start_scan(1'b0);
        goto(18);
        chk("t4_pre_valid", 32'(out_valid), 32'd1);
        chk("t4_pre_addr", 32'(out_addr), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_rst_valid", 32'(out_valid), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_rf_addr", 32'(rf_read_addr), 32'd0);
        chk("t4_rst_done", 32'(done), 32'd0);
        chk("t4_rst_out_addr", 32'(out_addr), 32'd0);
        repeat (5) tick();
        chk("t4_no_done", 32'(done_cnt), 32'd0);
        chk("t4_beats_before", 32'(beats), 32'd5);
        chk("t4_queue_drained", 32'(exp_q.size()), 32'd0);
        beats = 0;
        push_all();
        start_scan(1'b0);
        wait_done(dc);
        chk("t4_rescan_done_cycle", 32'(dc), 32'd25);
        finish_check("t4", 8);

`ifdef REGFILE_SCANNER_SKIP_ZERO_EN
        // Zero-valued registers produce no beat and cost two cycles each.
        beats = 0; done_cnt = 0;
        load(32'h0007_0030);
        push_all();
        start_scan(1'b0);
        wait_done(dc);
        chk("t6_sparse_done_cycle", 32'(dc), 32'd19);
        finish_check("t6_sparse", 2);

        beats = 0; done_cnt = 0;
        load(32'h0000_0000);
        push_all();
        start_scan(1'b0);
        wait_done(dc);
        chk("t6_zero_done_cycle", 32'(dc), 32'd17);
        finish_check("t6_zero", 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scanner.md
Name: regfile_scanner

Overview:
- Read-side initiator for the processor's 8x4 register file.
- On a start pulse, walks addresses 0..NUM_REGS-1 over the register file's read port. The read port has a registered one-cycle latency.
- Streams each (address, data) pair out on a valid/ready interface toward the debug/display path.
- Lets the board display or a test bench dump architectural state without stalling the datapath's other read port.

Parameters:
DATA_W, 4, register data width
ADDR_W, 3, register address width
NUM_REGS, 8, number of registers scanned (must be <= 2**ADDR_W)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  scan request; sampled only in IDLE
busy  output  1  high from the cycle after start is accepted until DONE completes
done  output  1  one-cycle pulse after the last beat is accepted
rf_read_addr  output  ADDR_W  registered address to the register file read port
rf_read_data  input  DATA_W  register file read data, valid one cycle after the address edge
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
out_addr  output  ADDR_W  address of the current beat
out_data  output  DATA_W  data of the current beat

Behaviour:
- Reset (clk edge with reset=1) clears every output and internal register:
  - state=IDLE, idx=0, rf_read_addr=0
  - out_valid=0, out_addr=0, out_data=0, busy=0, done=0
  - Reset wins over all other inputs, including mid-scan: any pending beat is dropped with no done pulse.
- rf_read_addr always equals idx (registered).
- FSM states: IDLE, ISSUE, CAPTURE, HOLD, DONE.
  - IDLE: start=1 -> idx<=0, busy<=1, go to ISSUE. start=0 -> stay.
  - ISSUE: 1 cycle. rf_read_addr is stable; the register file samples it at the closing edge. Go to CAPTURE.
  - CAPTURE: 1 cycle. rf_read_data is valid for idx. At the edge: out_data<=rf_read_data, out_addr<=idx, out_valid<=1. Go to HOLD.
  - HOLD: out_valid, out_addr and out_data stay stable until out_ready=1.
    - On handshake (out_valid & out_ready at the edge): out_valid<=0.
    - If idx==NUM_REGS-1 -> DONE; else idx<=idx+1 -> ISSUE.
  - DONE: done=1 and busy=0 for exactly this cycle; idx<=0; go to IDLE.
- Throughput: minimum 3 cycles per beat (ISSUE, CAPTURE, HOLD with ready high). A full 8-register scan with out_ready tied high takes 24 cycles from the start edge to entering DONE.
- start while not IDLE, including in the DONE cycle, is ignored; no queuing.
- out_ready while out_valid=0 has no effect.
- idx never wraps: the transition to DONE happens before increment past NUM_REGS-1.
- Register file writes during a scan are not blocked. Each beat reflects the register's content at its own ISSUE edge.

Optional Feature:
- Macro: REGFILE_SCANNER_SKIP_ZERO_EN.
- Defined:
  - In CAPTURE, if rf_read_data==0 the beat is suppressed: out_valid stays 0 and there is no HOLD.
  - Control advances directly: to DONE if idx==NUM_REGS-1, else idx+1 -> ISSUE.
  - Suppressed registers cost 2 cycles.
  - An all-zero register file produces zero beats, and done still pulses.
- Not defined: every register produces a beat, including zero values.

Decomposition:
- Package regfile_pkg holds:
  - localparams REGFILE_DATA_W=4, REGFILE_ADDR_W=3, REGFILE_NUM_REGS=8 (module parameter defaults reference these)
  - typedef enum logic [2:0] scan_state_t {IDLE, ISSUE, CAPTURE, HOLD, DONE}
  - typedef struct packed {addr, data} scan_beat_t
- No sub-module; FSM, index counter and output register live in one module. The bench instantiates this block together with the register file.

Test Plan:
1. Register file preloaded r0..r7 = 1..8, out_ready=1, pulse start -> 8 beats (addr 0..7, data 1..8) in order, one every 3 cycles; done pulses once in cycle 25 after the start edge; busy low afterwards.
2. Same preload, out_ready low for 5 cycles on beat addr=3 -> out_valid, out_addr=3, out_data=4 held stable for all 5 cycles; no beat lost or duplicated; done delayed by 5 cycles.
3. Start pulsed again in the cycle after acceptance and in the DONE cycle -> ignored; exactly 8 beats and one done.
4. Reset asserted while in HOLD on addr=5 -> next cycle out_valid=0, busy=0, rf_read_addr=0, no done. A new start then yields the full 0..7 sequence.
5. Write r2<=4'hA while idx=1 is in HOLD -> beat for addr 2 carries 4'hA.
6. With REGFILE_SCANNER_SKIP_ZERO_EN defined, file = {0,3,0,0,7,0,0,0} -> exactly two beats (2'h1:3, 3'h4:7), then done. All-zero file -> no beats, done pulses 16 cycles after start.
